// File: rtl/bcd_key_pkg.sv
// Shared constants and helpers for the keypad-to-BCD scheduler.
//   NUM_KEYS : number of decimal key lines (0..9)
//   DIGIT_W  : BCD digit width
//   IDX_W    : width of a key index
//   rr_next  : next index after idx, wrapping 9 -> 0
package bcd_key_pkg;
  localparam int NUM_KEYS = 10;
  localparam int DIGIT_W  = 4;
  localparam int IDX_W    = 4;

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
    return (idx >= IDX_W'(NUM_KEYS - 1)) ? '0 : idx + IDX_W'(1);
  endfunction
endpackage

// File: rtl/bcd_encoder.sv
// One-hot decimal to BCD encoder.
//   onehot : one-hot key select, bit i means decimal i
//   bcd    : 4-bit BCD value of the selected bit (0 when no bit set)
module bcd_encoder (
  input  logic [9:0] onehot,
  output logic [3:0] bcd
);
  always_comb begin
    bcd = '0;
    for (int i = 0; i < 10; i++)
      if (onehot[i]) bcd = bcd | 4'(i);
  end
endmodule

// File: rtl/rr_arbiter10.sv
// Combinational round-robin arbiter over the ten pending key requests.
// Search starts at last+1 and wraps modulo 10; first requester wins.
//   req       : pending request vector
//   en        : grant permitted this cycle (FIFO can accept a write)
//   last      : index of the most recent grant
//   grant     : one-hot grant (all zero when nothing granted)
//   grant_idx : index of the granted key (0 when nothing granted)
module rr_arbiter10
  import bcd_key_pkg::*;
(
  input  logic [NUM_KEYS-1:0] req,
  input  logic                en,
  input  logic [IDX_W-1:0]    last,
  output logic [NUM_KEYS-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx
);
  always_comb begin
    logic [IDX_W-1:0] idx;
    logic             found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = last;
    for (int k = 0; k < NUM_KEYS; k++) begin
      idx = rr_next(idx);
      if (en && !found && req[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = idx;
      end
    end
  end
endmodule

// File: rtl/bcd_key_scheduler.sv
// Debounces ten raw key lines, holds one pending request per key, and
// round-robin schedules them through a shared BCD encoder into a small
// digit FIFO drained by a valid/ready handshake.
//   clk, rst_n  : clock, synchronous active-low reset
//   key         : raw asynchronous key levels, bit i = decimal i pressed
//   digit_out   : BCD digit at FIFO head, 0 when empty
//   digit_valid : FIFO not empty
//   digit_ready : consumer accepts head when valid && ready
//   dropped     : one-cycle pulse when a press hits an already-pending key
//   busy        : any request pending or FIFO not empty
module bcd_key_scheduler
  import bcd_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key,
  output logic [DIGIT_W-1:0]  digit_out,
  output logic                digit_valid,
  input  logic                digit_ready,
  output logic                dropped,
  output logic                busy
);
  localparam int         PTR_W     = $clog2(FIFO_DEPTH);
  localparam int         CNT_W     = PTR_W + 1;
  localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_CYCLES);

  logic [NUM_KEYS-1:0]      key_q, armed, pending, press, drop_vec, grant;
  logic [NUM_KEYS-1:0][3:0] cnt;
  logic [IDX_W-1:0]         last, grant_idx;
  logic [DIGIT_W-1:0]       enc_digit;
  logic [DIGIT_W-1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         count;
  logic                     full, pop, wr_ok, push;

  // ---------------- debounce ----------------
  // A press fires on the sample that would bring the count to the target;
  // armed then stays low until the key is seen released.
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++)
      press[i] = key_q[i] && armed[i] && ((cnt[i] + 4'd1) == DB_TARGET);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q <= '0;
      cnt   <= '0;
      armed <= '1;
    end else begin
      key_q <= key;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (!key_q[i]) begin
          cnt[i]   <= '0;
          armed[i] <= 1'b1;
        end else if (press[i]) begin
          cnt[i]   <= '0;
          armed[i] <= 1'b0;
        end else if (armed[i]) begin
          cnt[i]   <= cnt[i] + 4'd1;
        end
      end
    end
  end

  // ---------------- pending / scheduler ----------------
  // A press on a key granted in the same cycle re-sets it and is not a drop.
  assign drop_vec = press & pending & ~grant;

  rr_arbiter10 u_arb (
    .req       (pending),
    .en        (wr_ok),
    .last      (last),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  bcd_encoder u_enc (
    .onehot (grant),
    .bcd    (enc_digit)
  );

  assign push = |grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
      last    <= IDX_W'(NUM_KEYS - 1);
      dropped <= 1'b0;
    end else begin
      pending <= (pending & ~grant) | press;
      dropped <= |drop_vec;
      if (push) last <= grant_idx;
    end
  end

  // ---------------- digit FIFO ----------------
  assign full        = (count == CNT_W'(FIFO_DEPTH));
  assign digit_valid = (count != '0);
  assign pop         = digit_valid && digit_ready;
  // Full FIFO can still take a write when the head leaves this cycle.
  assign wr_ok       = !full || pop;
  assign digit_out   = digit_valid ? mem[rd_ptr] : '0;
  assign busy        = (|pending) || digit_valid;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_digit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
endmodule

// File: tb/tb_bcd_key_scheduler.sv
// Directed bench for bcd_key_scheduler (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4).
module tb_bcd_key_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] key = '0;
  logic       digit_ready = 1'b0;
  logic [3:0] digit_out;
  logic       digit_valid, dropped, busy;

  int total = 0;
  int bad = 0;
  int drop_cnt = 0;
  int vseen = 0;

  bcd_key_scheduler #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key         (key),
    .digit_out   (digit_out),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .dropped     (dropped),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    if (dropped) drop_cnt++;
    if (digit_valid) vseen++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic head(input string tag, input logic [3:0] d);
    check({tag, "_valid"}, 32'(digit_valid), 32'd1);
    check({tag, "_digit"}, 32'(digit_out), 32'(d));
  endtask

  task automatic press(input int k);
    key = 10'(1 << k);
    repeat (7) step();
    key = '0;
    repeat (2) step();
  endtask

  initial begin
    // reset state
    repeat (3) step();
    check("rst_digit", 32'(digit_out), 0);
    check("rst_valid", 32'(digit_valid), 0);
    check("rst_dropped", 32'(dropped), 0);
    check("rst_busy", 32'(busy), 0);

    // single press of key 3
    rst_n = 1'b1;
    digit_ready = 1'b1;
    key = 10'b0000001000;
    vseen = 0;
    repeat (5) step();
    check("p1_early_valid", 32'(vseen), 0);
    check("p1_busy_pending", 32'(busy), 1);
    step();
    head("p1_e6", 4'd3);
    step();
    check("p1_e7_valid", 32'(digit_valid), 0);
    check("p1_e7_busy", 32'(busy), 0);
    vseen = 0;
    repeat (3) step();
    key = '0;
    repeat (2) step();
    check("p1_single", 32'(vseen), 0);

    // glitch on key 5, three cycles
    drop_cnt = 0;
    vseen = 0;
    key = 10'(1 << 5);
    repeat (3) step();
    key = '0;
    repeat (8) step();
    check("glitch_valid", 32'(vseen), 0);
    check("glitch_drop", 32'(drop_cnt), 0);
    check("glitch_busy", 32'(busy), 0);

    // simultaneous 3 and 7 from fresh reset (last=9)
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    key = 10'b0010001000;
    vseen = 0;
    repeat (5) step();
    check("sim_early_valid", 32'(vseen), 0);
    step();
    head("sim_first", 4'd3);
    step();
    head("sim_second", 4'd7);
    step();
    check("sim_empty", 32'(digit_valid), 0);
    key = '0;
    repeat (2) step();
    key = 10'(1 << 3);
    repeat (6) step();
    head("sim_again3", 4'd3);
    step();
    check("sim_again_empty", 32'(digit_valid), 0);
    key = '0;
    repeat (2) step();

    // backpressure: 1,2,4,8 fill FIFO, 9 waits pending
    drop_cnt = 0;
    digit_ready = 1'b0;
    press(1); press(2); press(4); press(8); press(9);
    head("bp_full_head", 4'd1);
    check("bp_busy", 32'(busy), 1);
    digit_ready = 1'b1;
    step(); head("bp_d2", 4'd2);
    step(); head("bp_d4", 4'd4);
    step(); head("bp_d8", 4'd8);
    step(); head("bp_d9", 4'd9);
    step();
    check("bp_empty", 32'(digit_valid), 0);
    check("bp_no_drop", 32'(drop_cnt), 0);

    // drop: FIFO full, key 6 pressed twice while pending
    digit_ready = 1'b0;
    press(1); press(2); press(4); press(8);
    drop_cnt = 0;
    press(6);
    check("drop_first_none", 32'(drop_cnt), 0);
    press(6);
    check("drop_once", 32'(drop_cnt), 1);
    head("drop_head", 4'd1);
    digit_ready = 1'b1;
    step(); head("drop_d2", 4'd2);
    step(); head("drop_d4", 4'd4);
    step(); head("drop_d8", 4'd8);
    step(); head("drop_d6", 4'd6);
    step();
    check("drop_empty", 32'(digit_valid), 0);
    vseen = 0;
    repeat (3) step();
    check("drop_single6", 32'(vseen), 0);

    // reset mid-operation with key 0 held
    digit_ready = 1'b0;
    press(5); press(7);
    head("mid_head", 4'd5);
    key = 10'b0000000001;
    step(); step();
    rst_n = 1'b0;
    step();
    check("mid_rst_digit", 32'(digit_out), 0);
    check("mid_rst_valid", 32'(digit_valid), 0);
    check("mid_rst_dropped", 32'(dropped), 0);
    check("mid_rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    vseen = 0;
    repeat (5) step();
    check("mid_early_valid", 32'(vseen), 0);
    step();
    head("mid_d0", 4'd0);
    digit_ready = 1'b1;
    step();
    check("mid_empty", 32'(digit_valid), 0);
    key = '0;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
